// File: rtl/kmkz_div_seq.sv
// kmkz_div_seq -- multi-cycle radix-2 restoring divider for the Execute stage.
//
// Handles DIV / DIVU / REM / REMU (x_fun_i = 100/101/110/111). A start
// (valid & is_div & !kill in IDLE) captures the operands. PREP then forms
// absolute values and result signs, ITER runs 32 restoring steps, FIX
// applies the signs and selects quotient/remainder, and DONE strobes the
// result for one cycle. A zero divisor can skip ITER (DIV_ZERO_FAST=1).
//
// Parameters:
//   DIV_ZERO_FAST - 1: zero divisor goes PREP->DONE directly
// Ports:
//   clk_i         - clock
//   rst_i         - synchronous reset, active low
//   x_valid_i     - Execute-stage instruction valid
//   x_is_div_i    - instruction is a divide/remainder
//   x_fun_i[2:0]  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   x_kill_i      - flush; aborts any operation in flight
//   rs1_i[31:0]   - dividend
//   rs2_i[31:0]   - divisor
//   x_stall_req_o - pipeline stall request (combinational)
//   div_done_o    - one-cycle strobe, div_result_o valid
//   div_result_o  - quotient or remainder, held until overwritten
//   div_busy_o    - FSM not in IDLE
module kmkz_div_seq #(
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_is_div_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_kill_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output logic        x_stall_req_o,
  output logic        div_done_o,
  output logic [31:0] div_result_o,
  output logic        div_busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] op_a_q,  op_a_d;   // original dividend, kept for zero-divisor remainder
  logic [31:0] dvsr_q,  dvsr_d;   // raw divisor until PREP, absolute value afterwards
  logic [1:0]  fun_q,   fun_d;    // [0]=unsigned, [1]=remainder
  logic [31:0] rem_q,   rem_d;
  logic [31:0] quot_q,  quot_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] result_q, result_d;

  logic        start;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // fun[2] is always 1 for divide ops; x_is_div_i already qualifies the op.
  logic unused_fun2;
  assign unused_fun2 = x_fun_i[2];

  always_comb begin
    start     = (state_q == S_IDLE) & x_valid_i & x_is_div_i & ~x_kill_i;
    is_signed = ~fun_q[0];
    a_neg     = is_signed & op_a_q[31];
    b_neg     = is_signed & dvsr_q[31];
    a_abs     = a_neg ? (32'd0 - op_a_q) : op_a_q;
    b_abs     = b_neg ? (32'd0 - dvsr_q) : dvsr_q;

    // Partial remainder is kept 33 bits wide: with an unsigned divisor near
    // 2^32 the shifted remainder can exceed 32 bits, and since it is always
    // below 2*divisor the 33-bit difference sign is exact.
    shifted   = {rem_q, quot_q[31]};
    diff      = shifted - {1'b0, dvsr_q};

    q_fix     = q_neg_q ? (32'd0 - quot_q) : quot_q;
    r_fix     = r_neg_q ? (32'd0 - rem_q)  : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    dvsr_d   = dvsr_q;
    fun_d    = fun_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          op_a_d  = rs1_i;
          dvsr_d  = rs2_i;
          fun_d   = x_fun_i[1:0];
        end
      end
      S_PREP: begin
        quot_d  = a_abs;
        rem_d   = '0;
        dvsr_d  = b_abs;
        cnt_d   = '0;
        q_neg_d = (a_neg ^ b_neg) & (dvsr_q != '0);
        r_neg_d = a_neg;
        if (DIV_ZERO_FAST && (dvsr_q == '0)) begin
          state_d  = S_DONE;
          result_d = fun_q[1] ? op_a_q : '1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        quot_d = {quot_q[30:0], ~diff[32]};
        rem_d  = diff[32] ? shifted[31:0] : diff[31:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fun_q[1] ? r_fix : q_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush abandons the operation and must not disturb the last result.
    if (x_kill_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      dvsr_q   <= '0;
      fun_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      dvsr_q   <= dvsr_d;
      fun_q    <= fun_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  // Status outputs are forced low while reset is asserted, even before the
  // reset edge has returned the FSM to IDLE.
  always_comb begin
    x_stall_req_o = rst_i & (start | (state_q == S_PREP) | (state_q == S_ITER) |
                             (state_q == S_FIX));
    div_done_o    = rst_i & (state_q == S_DONE);
    div_busy_o    = rst_i & (state_q != S_IDLE);
    div_result_o  = result_q;
  end

endmodule
